// File: rtl/fsm_me_if.sv
// Symbol/detect bundle for the fsm_me A,B,B recognizer.
// The master drives the symbol; the slave (recognizer) returns detect, count and symbol error.
interface fsm_me_if #(
    parameter int unsigned CNT_W = 8
);
    logic [1:0]       x;
    logic             z;
    logic [CNT_W-1:0] count;
    logic             sym_err;

    modport master (
        output x,
        input  z,
        input  count,
        input  sym_err
    );

    modport slave (
        input  x,
        output z,
        output count,
        output sym_err
    );
endinterface

// File: rtl/fsm_me.sv
// Mealy recognizer for the symbol sequence A,B,B with a saturating detection counter.
// Define FSM_ME_REG_OUT_EN to register z (one cycle later, glitch-free).
module fsm_me #(
    parameter int unsigned CNT_W = 8
) (
    input logic    clock,
    input logic    reset,
    fsm_me_if.slave bus
);
    localparam logic [1:0] SymA   = 2'b00;
    localparam logic [1:0] SymB   = 2'b01;
    localparam logic [1:0] SymIll = 2'b10;

    typedef enum logic [1:0] {
        S0  = 2'b00,
        Sa  = 2'b01,
        Sab = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             det;

    always_comb begin
        state_d = S0;
        det     = (state_q == Sab) && (bus.x == SymB);
        case (state_q)
            Sa: begin
                if (bus.x == SymA) begin
                    state_d = Sa;
                end else if (bus.x == SymB) begin
                    state_d = Sab;
                end
            end
            // B here is the detection; no overlap, so it falls back to S0.
            Sab: begin
                if (bus.x == SymA) begin
                    state_d = Sa;
                end
            end
            // S0 and the unreachable encoding 2'b11 behave identically.
            default: begin
                if (bus.x == SymA) begin
                    state_d = Sa;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (det && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

`ifdef FSM_ME_REG_OUT_EN
    logic z_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            z_q <= 1'b0;
        end else begin
            z_q <= det;
        end
    end

    assign bus.z = z_q;
`else
    assign bus.z = det && !reset;
`endif

    assign bus.count   = count_q;
    assign bus.sym_err = (bus.x == SymIll);
endmodule

// File: tb/tb_fsm_me.sv
// Scoreboard bench for fsm_me: two instances (CNT_W=8 and CNT_W=2) share one stimulus stream.
// The reference model matches A,B,B on the raw symbol history since the last detection or reset.
module tb_fsm_me;
    localparam logic [1:0] A = 2'b00;
    localparam logic [1:0] B = 2'b01;
    localparam logic [1:0] C = 2'b11;
    localparam logic [1:0] I = 2'b10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] x     = A;

    always #5 clock = ~clock;

    fsm_me_if #(.CNT_W(8)) bus8 ();
    fsm_me_if #(.CNT_W(2)) bus2 ();

    assign bus8.x = x;
    assign bus2.x = x;

    fsm_me #(.CNT_W(8)) u_dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8.slave)
    );

    fsm_me #(.CNT_W(2)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.slave)
    );

    typedef struct {
        bit z;
        int cnt8;
        int cnt2;
        bit err;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0] hist[$];
    int         m_cnt8 = 0;
    int         m_cnt2 = 0;
    bit         m_zreg = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive one symbol for one cycle and queue the expected mid-cycle outputs.
    task automatic step(input logic [1:0] sx, input bit rst);
        exp_t e;
        bit   det;
        int   n;
        @(posedge clock);
        #1;
        x     = sx;
        reset = rst;
        n     = hist.size();
        det   = !rst && (sx == B) && (n >= 2) && (hist[n-2] == A) && (hist[n-1] == B);
`ifdef FSM_ME_REG_OUT_EN
        e.z = m_zreg;
`else
        e.z = det;
`endif
        e.cnt8 = m_cnt8;
        e.cnt2 = m_cnt2;
        e.err  = (sx == I);
        sbq.push_back(e);
        if (rst) begin
            hist.delete();
            m_cnt8 = 0;
            m_cnt2 = 0;
            m_zreg = 1'b0;
        end else if (det) begin
            hist.delete();
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            m_zreg = 1'b1;
        end else begin
            hist.push_back(sx);
            m_zreg = 1'b0;
        end
    endtask

    task automatic run_seq(input logic [1:0] s[$]);
        foreach (s[i]) step(s[i], 1'b0);
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("z8", int'(bus8.z), int'(e.z));
                check("z2", int'(bus2.z), int'(e.z));
                check("count8", int'(bus8.count), e.cnt8);
                check("count2", int'(bus2.count), e.cnt2);
                check("sym_err", int'(bus8.sym_err), int'(e.err));
            end
        end
    end

    initial begin
        logic [1:0] s[$];
        logic [1:0] r;

        step(A, 1'b1);
        step(A, 1'b1);
        step(A, 1'b0);

        s = '{B, C, A, B, B};
        run_seq(s);
        s = '{A, A, A, B, B, C, A, B, B};
        run_seq(s);
        step(A, 1'b1);
        s = '{A, B, B, B};
        run_seq(s);
        s = '{A, B, A, B, B};
        run_seq(s);
        // Illegal symbol while in SAB, then B must not detect
        s = '{A, B, I, B, B};
        run_seq(s);
        // Drive the narrow counter into saturation
        for (int k = 0; k < 6; k++) begin
            s = '{A, B, B};
            run_seq(s);
        end
        // Reset asserted on the detecting symbol
        s = '{A, B};
        run_seq(s);
        step(B, 1'b1);
        step(B, 1'b0);

        for (int k = 0; k < 3000; k++) begin
            r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) r = 2'($urandom_range(0, 1));
            step(r, ($urandom_range(0, 99) < 2));
        end
        step(A, 1'b0);

        for (int k = 0; k < 4 && sbq.size() > 0; k++) @(negedge clock);
        @(posedge clock);
        check("scoreboard_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fsm_me.md
Name: fsm_me

Overview:
- Mealy finite-state recognizer for a 2-bit symbol stream. Symbols are A=2'b00, B=2'b01, C=2'b11, and 2'b10 is illegal.
- Asserts `z` combinationally during the cycle in which the last symbol of the sequence A,B,B is presented.
- Sits behind a symbol decoder as a small pattern-detect register stage. Also keeps a saturating count of detections.

Parameters:
- CNT_W, 8, width of the saturating detection counter `count`.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- x  input  2  current symbol; sampled every rising edge.
- z  output  1  Mealy detect output; 1 when state=SAB and x=B.
- count  output  CNT_W  number of detections since reset; saturates at all-ones.
- sym_err  output  1  combinational; 1 whenever x==2'b10.

Behaviour:
- Interface: one clock (`clock`). Reset `reset` is synchronous and active-high.
- States (2-bit encoding): S0=00 (no progress), SA=01 (seen A), SAB=10 (seen A,B). Encoding 11 is unreachable and is treated as S0.
- Reset, at the rising edge with reset=1:
  - state <= S0, count <= 0.
  - While reset=1, z is forced to 0; the symbol on x is discarded.
  - Reset mid-sequence discards all progress.
- Transitions, at each rising edge with reset=0:
  - S0: A->SA; B,C,illegal->S0.
  - SA: A->SA; B->SAB; C,illegal->S0.
  - SAB: A->SA; B->S0 (detection; non-overlapping); C,illegal->S0.
- Output z:
  - Combinational: z = (state==SAB) && (x==2'b01) && !reset.
  - Zero latency; z follows x within the same cycle.
  - z may glitch with x; consumers sample z at the rising edge.
- count:
  - Increments at the rising edge where z=1, unless already all-ones (saturate, no wrap).
  - Reset has priority over increment.
- sym_err:
  - Combinational, equal to (x==2'b10).
  - An illegal symbol also forces the next state to S0 and never produces z=1.
- Overlap rule: after A,B,B the machine returns to S0, so A,B,B,B yields one detection. A,B,A,B,B yields one detection (the second A restarts).
- Reset values: state=S0, z=0, count=0. sym_err depends only on x.

Optional Feature:
- Macro FSM_ME_REG_OUT_EN.
- When defined:
  - z is a registered output: z_q <= (state==SAB && x==B) at each rising edge.
  - z is then high for the full cycle after the detecting symbol (1-cycle latency, glitch-free).
  - z_q resets to 0 synchronously.
  - count increments on the same edge z_q is loaded to 1, so count updates simultaneously with the rise of z_q.
- When undefined: the default combinational Mealy z described above.

Test Plan:
- Reset for 2 cycles, then x=A -> z=0, count=0, state=SA after the edge.
- Stream A,B,C,A,B,B (one symbol per cycle) -> z=1 only during the 6th symbol; count=1 afterwards.
- Stream A,A,A,B,B,C,A,B,B -> z=1 during the 5th and 9th symbols only; count increments by 2.
- Stream A,B,B,B and A,B,A,B,B -> exactly one detection each (non-overlap and restart checks).
- x=2'b10 while in SAB -> sym_err=1, z=0, next state S0; a following B gives z=0.
- CNT_W=2, 5 detections -> count holds at 3. Assert reset in the cycle x=B while in SAB -> z=0, count=0.
